// File: rtl/imm_pkg.sv
// Shared opcode constants and format codes for the immediate generator.
package imm_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Instruction-in / immediate-out bus of the immediate generator.
// A transfer happens on a rising edge where valid and ready are both 1; a
// producer holds valid and its payload steady until that edge, and ready never
// looks at valid on the same side.
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal
    );

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal
    );
endinterface

// File: rtl/imm_decode.sv
// Combinational opcode decode and immediate assembly, sign-extended to XLEN.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [6:0]      opcode,
    input  logic [31:7]     instr,
    output fmt_e            fmt,
    output logic            illegal,
    output logic [XLEN-1:0] imm
);

    always_comb begin
        fmt     = FMT_R;
        illegal = 1'b0;
        imm     = '0;
        case (opcode)
            OPC_LUI, OPC_AUIPC:                       fmt = FMT_U;
            OPC_JAL:                                  fmt = FMT_J;
            OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_SYSTEM: fmt = FMT_I;
            OPC_STORE:                                fmt = FMT_S;
            OPC_BRANCH:                               fmt = FMT_B;
            OPC_OP:                                   fmt = FMT_R;
            default:                                  illegal = 1'b1;
        endcase
        // Every format takes its sign from instr[31]; replication counts stay positive for XLEN=32.
        case (fmt)
            FMT_I: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
            FMT_S: imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U: imm = {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0};
            FMT_J: imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode feeds a registered output stage,
// optionally backed by a skid register so backpressure never drops a word.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit SKID_EN = 1'b1
) (
    input logic           clk,
    input logic           rst,
    imm_gen_pipe_if.slave bus
);

    typedef struct packed {
        logic            illegal;
        fmt_e            fmt;
        logic [XLEN-1:0] imm;
    } entry_t;

    fmt_e            dec_fmt;
    logic            dec_ill;
    logic [XLEN-1:0] dec_imm;
    entry_t          dec_e;
    entry_t          main_q;
    entry_t          skid_q;
    logic            main_valid;
    logic            skid_valid;
    logic            in_ready_int;
    logic            accept;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .opcode  (bus.in_instr[6:0]),
        .instr   (bus.in_instr[31:7]),
        .fmt     (dec_fmt),
        .illegal (dec_ill),
        .imm     (dec_imm)
    );

    assign dec_e = '{illegal: dec_ill, fmt: dec_fmt, imm: dec_imm};

    // Without the skid register the stage can only take a word when main empties this edge.
    assign in_ready_int = SKID_EN ? !skid_valid : (!main_valid || bus.out_ready);
    assign accept       = bus.in_valid && in_ready_int;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (!main_valid || bus.out_ready) begin
            // Main is free or draining: the skid entry is older, so it wins over a new word.
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                main_valid <= accept;
                if (accept) begin
                    main_q <= dec_e;
                end
            end
        end else if (accept) begin
            skid_q     <= dec_e;
            skid_valid <= 1'b1;
        end
    end

    assign bus.in_ready    = in_ready_int;
    assign bus.out_valid   = main_valid;
    assign bus.out_imm     = main_q.imm;
    assign bus.out_fmt     = main_q.fmt;
    assign bus.out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit skid instance and a 64-bit single-register
// instance, fed from a vector table, hand sequences and a random stream.
module tb_imm_gen_pipe;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    bit   rand_ready;

    logic [67:0] exp_q32[$];
    logic [67:0] exp_q64[$];

    imm_gen_pipe_if #(.XLEN(32)) bus32();
    imm_gen_pipe_if #(.XLEN(64)) bus64();

    imm_gen_pipe #(.XLEN(32), .SKID_EN(1'b1)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (bus32)
    );

    imm_gen_pipe #(.XLEN(64), .SKID_EN(1'b0)) dut64 (
        .clk (clk),
        .rst (rst),
        .bus (bus64)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Independent reference: immediates built by arithmetic shifts of the sign-extended word.
    function automatic logic [67:0] model(input logic [31:0] ins);
        logic signed [63:0] si;
        logic [63:0]        sgn;
        logic [63:0]        imm;
        logic [2:0]         fmt;
        logic               ill;
        si  = {{32{ins[31]}}, ins};
        sgn = si >>> 31;
        imm = '0;
        fmt = 3'd0;
        ill = 1'b0;
        case (ins[6:0])
            7'h37, 7'h17: begin fmt = 3'd4; imm = si & ~64'hFFF; end
            7'h6F: begin
                fmt = 3'd5;
                imm = (sgn << 20) | ({56'b0, ins[19:12]} << 12) | ({63'b0, ins[20]} << 11)
                      | ({54'b0, ins[30:21]} << 1);
            end
            7'h67, 7'h03, 7'h13, 7'h73: begin fmt = 3'd1; imm = si >>> 20; end
            7'h23: begin
                fmt = 3'd2;
                imm = si >>> 25;
                imm = (imm << 5) | {59'b0, ins[11:7]};
            end
            7'h63: begin
                fmt = 3'd3;
                imm = (sgn << 12) | ({63'b0, ins[7]} << 11) | ({58'b0, ins[30:25]} << 5)
                      | ({60'b0, ins[11:8]} << 1);
            end
            7'h33: fmt = 3'd0;
            default: ill = 1'b1;
        endcase
        return {ill, fmt, imm};
    endfunction

    // ---------------- driver ----------------
    task automatic send(input int which, input logic [31:0] ins, input logic [67:0] e);
        bit done;
        done = 1'b0;
        if (which == 0) begin bus32.in_valid = 1'b1; bus32.in_instr = ins; end
        else            begin bus64.in_valid = 1'b1; bus64.in_instr = ins; end
        for (int n = 0; n < 64 && !done; n++) begin
            @(negedge clk);
            if ((which == 0) ? bus32.in_ready : bus64.in_ready) begin
                if (which == 0) exp_q32.push_back(e);
                else            exp_q64.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (rand_ready) begin
                bus32.out_ready = 1'($urandom_range(0, 1));
                bus64.out_ready = 1'($urandom_range(0, 1));
            end
        end
        if (which == 0) bus32.in_valid = 1'b0;
        else            bus64.in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: instr %h never accepted by dut %0d", ins, which);
        end
    endtask

    // ---------------- scoreboard / monitors ----------------
    logic [68:0] held32;
    bit          stall32;

    always @(negedge clk) begin
        logic [67:0] e;
        logic [68:0] cur;
        cur = {bus32.out_valid, bus32.out_illegal, bus32.out_fmt, 32'h0, bus32.out_imm};
        if (!rst && stall32) check("stable32", {cur[67:0]} | {67'b0, 1'b0}, held32[67:0]);
        if (!rst && stall32) check("stable32_valid", {67'b0, cur[68]}, 68'd1);
        stall32 = !rst && bus32.out_valid && !bus32.out_ready;
        held32  = cur;
        if (!rst && bus32.out_valid && bus32.out_ready) begin
            if (exp_q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out32_extra: got %h with nothing expected", cur[67:0]);
            end else begin
                e = exp_q32.pop_front();
                check("out32", cur[67:0], {e[67:64], 32'h0, e[31:0]});
            end
        end
    end

    always @(negedge clk) begin
        logic [67:0] e;
        if (!rst && bus64.out_valid && bus64.out_ready) begin
            if (exp_q64.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out64_extra: got %h with nothing expected",
                         {bus64.out_illegal, bus64.out_fmt, bus64.out_imm});
            end else begin
                e = exp_q64.pop_front();
                check("out64", {bus64.out_illegal, bus64.out_fmt, bus64.out_imm}, e);
            end
        end
    end

    // ---------------- vectors ----------------
    typedef struct {
        logic [31:0] instr;
        logic [2:0]  fmt;
        logic        ill;
        logic [31:0] imm;
    } vec_t;

    vec_t tbl[12];

    function automatic logic [67:0] vec_exp(input vec_t v);
        return {v.ill, v.fmt, {32{v.imm[31]}}, v.imm};
    endfunction

    initial begin
        logic [67:0] ea;
        logic [67:0] eb;
        logic [67:0] ec;
        logic [6:0]  opcs[11];
        logic [31:0] ins;

        tbl[0]  = '{32'hFE512E23, 3'd2, 1'b0, 32'hFFFFFFFC}; // sw x5,-4(x2)
        tbl[1]  = '{32'h123450B7, 3'd4, 1'b0, 32'h12345000}; // lui x1,0x12345
        tbl[2]  = '{32'hFF9FF06F, 3'd5, 1'b0, 32'hFFFFFFF8}; // jal x0,-8
        tbl[3]  = '{32'h00208863, 3'd3, 1'b0, 32'h00000010}; // beq x1,x2,16
        tbl[4]  = '{32'h0000007F, 3'd0, 1'b1, 32'h00000000}; // illegal
        tbl[5]  = '{32'hFFF00093, 3'd1, 1'b0, 32'hFFFFFFFF}; // addi x1,x0,-1
        tbl[6]  = '{32'h002081B3, 3'd0, 1'b0, 32'h00000000}; // add x3,x1,x2
        tbl[7]  = '{32'h00008067, 3'd1, 1'b0, 32'h00000000}; // jalr x0,0(x1)
        tbl[8]  = '{32'h00812283, 3'd1, 1'b0, 32'h00000008}; // lw x5,8(x2)
        tbl[9]  = '{32'hFFFFF117, 3'd4, 1'b0, 32'hFFFFF000}; // auipc x2,0xFFFFF
        tbl[10] = '{32'h00000073, 3'd1, 1'b0, 32'h00000000}; // ecall
        tbl[11] = '{32'h7FF00093, 3'd1, 1'b0, 32'h000007FF}; // addi x1,x0,2047

        opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h73, 7'h23, 7'h63, 7'h33, 7'h5B};

        checks = 0;
        errors = 0;
        rand_ready = 1'b0;
        rst = 1'b1;
        bus32.in_valid = 1'b0; bus32.in_instr = '0; bus32.out_ready = 1'b1;
        bus64.in_valid = 1'b0; bus64.in_instr = '0; bus64.out_ready = 1'b1;

        // Reset state
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_valid32", {67'b0, bus32.out_valid}, 68'd0);
        check("rst_imm32", {36'b0, bus32.out_imm}, 68'd0);
        check("rst_fmt32", {65'b0, bus32.out_fmt}, 68'd0);
        check("rst_ill32", {67'b0, bus32.out_illegal}, 68'd0);
        check("rst_valid64", {67'b0, bus64.out_valid}, 68'd0);
        check("rst_imm64", {4'b0, bus64.out_imm}, 68'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready32", {67'b0, bus32.in_ready}, 68'd1);
        check("post_rst_ready64", {67'b0, bus64.in_ready}, 68'd1);
        @(posedge clk); #1;

        // One-cycle latency from accept to out_valid
        send(0, tbl[0].instr, vec_exp(tbl[0]));
        @(negedge clk);
        check("latency_valid", {67'b0, bus32.out_valid}, 68'd1);
        check("latency_fmt", {65'b0, bus32.out_fmt}, 68'd2);
        @(posedge clk); #1;

        // Vector table through both instances
        for (int i = 0; i < 12; i++) send(0, tbl[i].instr, vec_exp(tbl[i]));
        for (int i = 0; i < 12; i++) send(1, tbl[i].instr, vec_exp(tbl[i]));
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: two fill main and skid, third is refused
        ea = model(32'h123450B7);
        eb = model(32'hFF9FF06F);
        ec = model(32'h00208863);
        bus32.out_ready = 1'b0;
        bus32.in_valid = 1'b1;
        bus32.in_instr = 32'h123450B7;
        @(negedge clk);
        check("bp_ready_a", {67'b0, bus32.in_ready}, 68'd1);
        exp_q32.push_back(ea);
        @(posedge clk); #1;
        bus32.in_instr = 32'hFF9FF06F;
        @(negedge clk);
        check("bp_ready_b", {67'b0, bus32.in_ready}, 68'd1);
        exp_q32.push_back(eb);
        @(posedge clk); #1;
        bus32.in_instr = 32'h00208863;
        @(negedge clk);
        check("bp_full_ready_c", {67'b0, bus32.in_ready}, 68'd0);
        check("bp_head_imm", {36'b0, bus32.out_imm}, {36'b0, ea[31:0]});
        @(posedge clk); #1;
        bus32.out_ready = 1'b1;
        @(negedge clk);
        check("bp_still_full", {67'b0, bus32.in_ready}, 68'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_ready_back", {67'b0, bus32.in_ready}, 68'd1);
        if (bus32.in_ready) exp_q32.push_back(ec);
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset with main and skid both holding entries
        bus32.out_ready = 1'b0;
        send(0, 32'h0000007F, model(32'h0000007F));
        send(0, 32'hFE512E23, model(32'hFE512E23));
        @(negedge clk);
        check("full_ready", {67'b0, bus32.in_ready}, 68'd0);
        check("full_illegal", {67'b0, bus32.out_illegal}, 68'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q32.delete();
        exp_q64.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_valid", {67'b0, bus32.out_valid}, 68'd0);
        check("midrst_ready", {67'b0, bus32.in_ready}, 68'd1);
        check("midrst_ill", {67'b0, bus32.out_illegal}, 68'd0);
        check("midrst_imm", {36'b0, bus32.out_imm}, 68'd0);
        @(posedge clk); #1;
        bus32.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("no_replay", {67'b0, bus32.out_valid}, 68'd0);
            @(posedge clk); #1;
        end

        // Random stream with random backpressure on both instances
        rand_ready = 1'b1;
        for (int i = 0; i < 160; i++) begin
            ins = {$urandom(), 7'h00} | {25'b0, opcs[$urandom_range(0, 10)]};
            send(i % 2, ins, model(ins));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        rand_ready = 1'b0;
        bus32.out_ready = 1'b1;
        bus64.out_ready = 1'b1;
        for (int k = 0; k < 200 && (exp_q32.size() != 0 || exp_q64.size() != 0); k++) begin
            @(posedge clk); #1;
        end
        check("drain_left", {36'b0, 32'(exp_q32.size() + exp_q64.size())}, 68'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
